// File: rtl/st_port_arbiter_pkg.sv
// Shared types for the store-port arbiter: core-side dcache request/response
// structs, the arbiter FSM encoding and the per-port write request record.
package st_port_arbiter_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;
  localparam int unsigned ST_ARB_NR_PORTS    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } st_arb_state_e;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] index;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic [63:0]                   wdata;
    logic [7:0]                    be;
    logic [1:0]                    size;
  } st_wr_req_t;

  // Pointer width that stays legal for a single-port build.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/st_port_arbiter_rr_starve_sel.sv
// Combinational winner selector: starved requesters first (lowest index),
// otherwise round-robin starting at rr_ptr_i.
module rr_starve_sel
  import st_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned PTR_W    = ptr_width(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]    rr_ptr_i,
  input  logic [NR_PORTS-1:0] starved_i,
  output logic                valid_o,
  output logic [NR_PORTS-1:0] winner_oh_o,
  output logic [PTR_W-1:0]    winner_idx_o
);

  always_comb begin
    logic              found;
    logic [PTR_W-1:0]  idx;
    found        = 1'b0;
    idx          = '0;
    winner_idx_o = '0;
    winner_oh_o  = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (!found && req_i[i] && starved_i[i]) begin
        found        = 1'b1;
        winner_idx_o = PTR_W'(i);
      end
    end
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      idx = PTR_W'((32'(rr_ptr_i) + k) % NR_PORTS);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        winner_idx_o = idx;
      end
    end
    valid_o = found;
    if (found) winner_oh_o[winner_idx_o] = 1'b1;
  end

endmodule

// File: rtl/st_port_arbiter.sv
// Round-robin store-port arbiter with request lock and starvation escape.
// Optional perf outputs are built when ST_ARB_PERF_EN is defined.
module st_port_arbiter
  import st_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS     = ST_ARB_NR_PORTS,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   hold_i,
  input  logic [NR_PORTS-1:0]                    req_i,
  input  logic [NR_PORTS*DCACHE_INDEX_WIDTH-1:0] index_i,
  input  logic [NR_PORTS*DCACHE_TAG_WIDTH-1:0]   tag_i,
  input  logic [NR_PORTS*64-1:0]                 wdata_i,
  input  logic [NR_PORTS*8-1:0]                  be_i,
  input  logic [NR_PORTS*2-1:0]                  size_i,
  output logic [NR_PORTS-1:0]                    gnt_o,
  input  dcache_req_o_t                          req_port_i,
  output dcache_req_i_t                          req_port_o,
  output logic                                   busy_o
`ifdef ST_ARB_PERF_EN
  ,
  output logic                                   perf_conflict_o,
  output logic                                   perf_stall_o
`endif
);

  localparam int unsigned PTR_W = ptr_width(NR_PORTS);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  st_arb_state_e                   state_q, state_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                lock_idx_q, lock_idx_d;
  logic [NR_PORTS-1:0][CNT_W-1:0]  starve_q, starve_d;

  st_wr_req_t [NR_PORTS-1:0] wr_req;
  logic [NR_PORTS-1:0]       starved;
  logic                      win_valid;
  logic [NR_PORTS-1:0]       win_oh;
  logic [PTR_W-1:0]          win_idx;
  logic [PTR_W-1:0]          sel_idx;
  logic                      data_req;
  logic                      unused_rsp;

  assign unused_rsp = ^{req_port_i.data_rvalid, req_port_i.data_rdata};

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NR_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      wr_req[p].index = index_i[p*DCACHE_INDEX_WIDTH +: DCACHE_INDEX_WIDTH];
      wr_req[p].tag   = tag_i[p*DCACHE_TAG_WIDTH +: DCACHE_TAG_WIDTH];
      wr_req[p].wdata = wdata_i[p*64 +: 64];
      wr_req[p].be    = be_i[p*8 +: 8];
      wr_req[p].size  = size_i[p*2 +: 2];
      starved[p]      = (starve_q[p] == CNT_MAX);
    end
  end

  rr_starve_sel #(
    .NR_PORTS (NR_PORTS),
    .PTR_W    (PTR_W)
  ) u_sel (
    .req_i        (req_i),
    .rr_ptr_i     (rr_ptr_q),
    .starved_i    (starved),
    .valid_o      (win_valid),
    .winner_oh_o  (win_oh),
    .winner_idx_o (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    starve_d   = starve_q;
    gnt_o      = '0;
    data_req   = 1'b0;
    sel_idx    = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (!hold_i && win_valid) begin
          data_req = 1'b1;
          sel_idx  = win_idx;
          for (int unsigned p = 0; p < NR_PORTS; p++) begin
            if (req_i[p] && !win_oh[p] && (starve_q[p] != CNT_MAX)) begin
              starve_d[p] = starve_q[p] + 1'b1;
            end
          end
          if (req_port_i.data_gnt) begin
            gnt_o             = win_oh;
            rr_ptr_d          = next_ptr(win_idx);
            starve_d[win_idx] = '0;
          end else begin
            lock_idx_d = win_idx;
            state_d    = LOCK;
          end
        end
      end
      LOCK: begin
        data_req = 1'b1;
        sel_idx  = lock_idx_q;
        if (req_port_i.data_gnt) begin
          gnt_o[lock_idx_q]    = 1'b1;
          rr_ptr_d             = next_ptr(lock_idx_q);
          starve_d[lock_idx_q] = '0;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Requests and grants must vanish the moment reset is applied, even with
    // requesters still active against the reset IDLE state.
    if (!rst_ni) begin
      gnt_o    = '0;
      data_req = 1'b0;
    end
  end

  always_comb begin
    req_port_o               = '0;
    req_port_o.address_index = wr_req[sel_idx].index;
    req_port_o.address_tag   = wr_req[sel_idx].tag;
    req_port_o.data_wdata    = wr_req[sel_idx].wdata;
    req_port_o.data_be       = wr_req[sel_idx].be;
    req_port_o.data_size     = wr_req[sel_idx].size;
    req_port_o.data_req      = data_req;
    req_port_o.data_we       = 1'b1;
    req_port_o.kill_req      = 1'b0;
    req_port_o.tag_valid     = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      starve_q   <= starve_d;
    end
  end

  assign busy_o = (state_q == LOCK);

`ifdef ST_ARB_PERF_EN
  assign perf_conflict_o = (state_q == IDLE) && ($countones(req_i) > 1);
  assign perf_stall_o    = data_req && !req_port_i.data_gnt;
`endif

  // A locked requester must keep its request up until it is granted.
  a_lock_req_held: assert property (
    @(posedge clk_i) disable iff (!rst_ni) (state_q == LOCK) |-> req_i[lock_idx_q]
  );

endmodule

// File: tb/tb_st_port_arbiter.sv
// Directed self-checking bench for st_port_arbiter (3-port build so that a
// single requester can be starved against two others).
module tb_st_port_arbiter;
  import st_port_arbiter_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned IW = DCACHE_INDEX_WIDTH;
  localparam int unsigned TW = DCACHE_TAG_WIDTH;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                hold;
  logic [NP-1:0]       req;
  logic [NP*IW-1:0]    index_v;
  logic [NP*TW-1:0]    tag_v;
  logic [NP*64-1:0]    wdata_v;
  logic [NP*8-1:0]     be_v;
  logic [NP*2-1:0]     size_v;
  logic [NP-1:0]       gnt;
  dcache_req_o_t       rsp;
  dcache_req_i_t       dreq;
  logic                busy;

  logic [IW-1:0] exp_index [NP] = '{12'h012, 12'h034, 12'h056};
  logic [TW-1:0] exp_tag   [NP] = '{44'h0000_0000_A00, 44'h0000_0000_B11, 44'h0000_0000_C22};
  logic [63:0]   exp_wdata [NP] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
  logic [7:0]    exp_be    [NP] = '{8'hFF, 8'h0F, 8'hF0};
  logic [1:0]    exp_size  [NP] = '{2'd3, 2'd1, 2'd2};

  int tests_run = 0;
  int tests_failed = 0;

  st_port_arbiter #(.NR_PORTS(NP), .STARVE_LIMIT(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .hold_i     (hold),
    .req_i      (req),
    .index_i    (index_v),
    .tag_i      (tag_v),
    .wdata_i    (wdata_v),
    .be_i       (be_v),
    .size_i     (size_v),
    .gnt_o      (gnt),
    .req_port_i (rsp),
    .req_port_o (dreq),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [NP-1:0] r, input logic g, input logic h);
    @(negedge clk);
    req          = r;
    rsp.data_gnt = g;
    hold         = h;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; rsp.data_gnt = 1'b0; hold = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; req = 3'b011; rsp = '0; rsp.data_gnt = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (dreq.data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_data_req: got %b want 0", dreq.data_req); end
    tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_gnt: got %b want 000", gnt); end
    tests_run++; if (dreq.data_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL const_we: got %b want 1", dreq.data_we); end
    tests_run++; if (dreq.kill_req !== 1'b0 || dreq.tag_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL const_kill_tag: got %b%b want 00", dreq.kill_req, dreq.tag_valid); end
    @(negedge clk);
    req = '0; rsp.data_gnt = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_same_cycle();
    drive(3'b001, 1'b1, 1'b0);
    tests_run++; if (dreq.data_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_data_req: got %b want 1", dreq.data_req); end
    tests_run++; if (dreq.address_index !== 12'h012) begin tests_failed++; $display("[TB] FAIL same_index: got %h want 012", dreq.address_index); end
    tests_run++; if (dreq.data_be !== 8'hFF) begin tests_failed++; $display("[TB] FAIL same_be: got %h want ff", dreq.data_be); end
    tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("[TB] FAIL same_gnt: got %b want 001", gnt); end
    drive(3'b000, 1'b0, 1'b0);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL same_stays_idle: got %b want 0", busy); end
    tests_run++; if (dreq.data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_no_req: got %b want 0", dreq.data_req); end
  endtask

  task automatic test_lock();
    logic [NP-1:0] eg;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      drive(3'b011, (c == 4), 1'b0);
      eg = (c == 4) ? 3'b001 : 3'b000;
      tests_run++; if (dreq.data_req !== 1'b1 || dreq.address_index !== exp_index[0] || dreq.data_wdata !== exp_wdata[0] || dreq.address_tag !== exp_tag[0])
        begin tests_failed++; $display("[TB] FAIL lock_fields c%0d: got req=%b idx=%h want req=1 idx=%h", c, dreq.data_req, dreq.address_index, exp_index[0]); end
      tests_run++; if (busy !== (c > 1)) begin tests_failed++; $display("[TB] FAIL lock_busy c%0d: got %b want %b", c, busy, (c > 1)); end
      tests_run++; if (gnt !== eg) begin tests_failed++; $display("[TB] FAIL lock_gnt c%0d: got %b want %b", c, gnt, eg); end
    end
    drive(3'b010, 1'b1, 1'b0);
    tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("[TB] FAIL lock_next_gnt: got %b want 010", gnt); end
    tests_run++; if (dreq.address_index !== exp_index[1] || dreq.data_be !== exp_be[1] || dreq.data_size !== exp_size[1])
      begin tests_failed++; $display("[TB] FAIL lock_next_fields: got idx=%h be=%h want idx=%h be=%h", dreq.address_index, dreq.data_be, exp_index[1], exp_be[1]); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_next_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [NP-1:0] eg;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(3'b011, 1'b1, 1'b0);
      eg = (i % 2 == 0) ? 3'b001 : 3'b010;
      tests_run++; if (gnt !== eg) begin tests_failed++; $display("[TB] FAIL alt_gnt %0d: got %b want %b", i, gnt, eg); end
      tests_run++; if (dreq.address_index !== exp_index[i % 2]) begin tests_failed++; $display("[TB] FAIL alt_index %0d: got %h want %h", i, dreq.address_index, exp_index[i % 2]); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(3'b010, 1'b1, 1'b1);
      tests_run++; if (dreq.data_req !== 1'b0 || gnt !== 3'b000) begin tests_failed++; $display("[TB] FAIL hold_idle %0d: got req=%b gnt=%b want req=0 gnt=000", i, dreq.data_req, gnt); end
    end
    drive(3'b010, 1'b0, 1'b0);
    tests_run++; if (dreq.data_req !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_lock_entry: got req=%b busy=%b want 1 0", dreq.data_req, busy); end
    drive(3'b010, 1'b0, 1'b1);
    tests_run++; if (busy !== 1'b1 || dreq.data_req !== 1'b1 || dreq.address_index !== exp_index[1])
      begin tests_failed++; $display("[TB] FAIL hold_in_lock: got busy=%b req=%b idx=%h want 1 1 %h", busy, dreq.data_req, dreq.address_index, exp_index[1]); end
    drive(3'b010, 1'b1, 1'b1);
    tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("[TB] FAIL hold_lock_gnt: got %b want 010", gnt); end
    drive(3'b000, 1'b0, 1'b1);
    tests_run++; if (busy !== 1'b0 || dreq.data_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_after: got busy=%b req=%b want 0 0", busy, dreq.data_req); end
  endtask

  task automatic test_starve();
    do_reset();
    for (int r = 0; r < 8; r++) begin
      drive(3'b011, 1'b1, 1'b0);
      tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("[TB] FAIL starve_lose %0d: got %b want 001", r, gnt); end
      drive(3'b100, 1'b1, 1'b0);
      tests_run++; if (gnt !== 3'b100) begin tests_failed++; $display("[TB] FAIL starve_p2 %0d: got %b want 100", r, gnt); end
    end
    drive(3'b011, 1'b1, 1'b0);
    tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("[TB] FAIL starve_forced: got %b want 010", gnt); end
    drive(3'b100, 1'b1, 1'b0);
    tests_run++; if (gnt !== 3'b100) begin tests_failed++; $display("[TB] FAIL starve_rr_after: got %b want 100", gnt); end
    drive(3'b011, 1'b1, 1'b0);
    tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("[TB] FAIL starve_cleared: got %b want 001", gnt); end
  endtask

  task automatic test_reset_in_lock();
    do_reset();
    drive(3'b001, 1'b1, 1'b0);
    drive(3'b010, 1'b0, 1'b0);
    drive(3'b010, 1'b0, 1'b0);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rlock_busy: got %b want 1", busy); end
    rsp.data_gnt = 1'b1;
    #1;
    tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("[TB] FAIL rlock_pre_gnt: got %b want 010", gnt); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (dreq.data_req !== 1'b0 || gnt !== 3'b000 || busy !== 1'b0)
      begin tests_failed++; $display("[TB] FAIL rlock_async: got req=%b gnt=%b busy=%b want 0 000 0", dreq.data_req, gnt, busy); end
    @(negedge clk);
    rst_n = 1'b1; req = 3'b011; rsp.data_gnt = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rlock_idle: got %b want 0", busy); end
    tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("[TB] FAIL rlock_rr0: got %b want 001", gnt); end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      index_v[p*IW +: IW] = exp_index[p];
      tag_v[p*TW +: TW]   = exp_tag[p];
      wdata_v[p*64 +: 64] = exp_wdata[p];
      be_v[p*8 +: 8]      = exp_be[p];
      size_v[p*2 +: 2]    = exp_size[p];
    end
    test_reset();
    test_same_cycle();
    test_lock();
    test_back_to_back();
    test_hold();
    test_starve();
    test_reset_in_lock();
    @(negedge clk);
    req = '0; rsp.data_gnt = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/st_port_arbiter.md
Name: st_port_arbiter

Overview:
- Shares the single D$ store request port between NR_PORTS write requesters. Port 0 is the store buffer commit queue; the other ports are AMO/CSR-side writers.
- Round-robin arbitration with a request lock: once a requester is presented to the cache, it stays selected until the cache grants it.
- Sits between the store units and the dcache port mux, on the core-side `dcache_req_i_t` / `dcache_req_o_t` boundary.

Parameters:
- NR_PORTS, 2, number of write requesters (2..4).
- STARVE_LIMIT, 8, consecutive lost arbitration cycles after which a requester gets forced priority.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- hold_i  in  1  pause new arbitration; a locked request still completes
- req_i  in  NR_PORTS  per-port write request valid
- index_i  in  NR_PORTS*DCACHE_INDEX_WIDTH  per-port address index
- tag_i  in  NR_PORTS*DCACHE_TAG_WIDTH  per-port address tag
- wdata_i  in  NR_PORTS*64  per-port write data, already lane-aligned
- be_i  in  NR_PORTS*8  per-port byte enables
- size_i  in  NR_PORTS*2  per-port access size
- gnt_o  in/out: out  NR_PORTS  one-hot grant, pulses in the cycle the cache grants
- req_port_i  in  dcache_req_o_t  cache response (only data_gnt used)
- req_port_o  out  dcache_req_i_t  cache request
- busy_o  out  1  locked request outstanding (FSM in LOCK)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low. Reset mid-request aborts the lock and returns to IDLE.
- Reset values: state IDLE, rr_ptr 0, lock_idx 0, all starve counters 0, gnt_o 0, req_port_o.data_req 0, busy_o 0.
- Constant outputs: data_we=1, kill_req=0, tag_valid=0.
- FSM states: IDLE and LOCK.
- IDLE:
  - If hold_i=0 and any req_i is set, select a winner combinationally.
  - Drive data_req=1 and mux the winner's fields in the same cycle (zero added latency).
  - If data_gnt is high: gnt_o[winner]=1, rr_ptr <= winner+1 mod NR_PORTS, stay in IDLE.
  - If data_gnt is low: lock_idx <= winner, go to LOCK.
- LOCK:
  - data_req=1 and fields are muxed from lock_idx, regardless of hold_i and of other requests.
  - On data_gnt: gnt_o[lock_idx]=1, rr_ptr <= lock_idx+1, return to IDLE.
  - Requesters must hold req_i and data stable until granted. Dropping req_i while locked is a protocol error (asserted). The arbiter still completes the locked transfer.
- Winner selection:
  - If any port's starve counter has reached STARVE_LIMIT, the lowest such index wins.
  - Otherwise, the first requesting port at or after rr_ptr, wrapping modulo NR_PORTS.
- Starve counters, one per port (width $clog2(STARVE_LIMIT+1)):
  - Increment, saturating at STARVE_LIMIT, each IDLE cycle in which the port requests but is not the winner.
  - Clear on grant to that port.
  - Hold while hold_i=1 or in LOCK.
- hold_i=1 in IDLE: data_req=0, no grants, state unchanged.
- No requests: data_req=0, muxed fields come from port rr_ptr (don't-care).
- Grant latency: at most 1 + (NR_PORTS-1) × (cache grant latency) arbitration rounds. Starvation bound: STARVE_LIMIT lost cycles.

Optional Feature:
- Macro ST_ARB_PERF_EN.
- When defined:
  - Add output perf_conflict_o (1 bit): pulses in every IDLE cycle where two or more req_i are set.
  - Add output perf_stall_o (1 bit): high each cycle data_req=1 and data_gnt=0.
- When undefined: neither port nor logic exists.

Decomposition:
- ariane_pkg additions:
  - ST_ARB_NR_PORTS constant.
  - st_arb_state_e enum (IDLE, LOCK).
  - st_wr_req_t struct (index, tag, wdata, be, size), used to unpack the flat inputs.
- One sub-module, rr_starve_sel: a combinational winner selector taking req, rr_ptr and the starve-saturated flags, returning a one-hot winner plus index. The FSM, counters and mux stay in st_port_arbiter.

Test Plan:
- Port 0 req, index 0x12, be 0xFF, data_gnt same cycle -> data_req=1 that cycle, gnt_o=01, state stays IDLE, no added latency.
- Ports 0 and 1 req together, rr_ptr=0, gnt withheld 3 cycles -> fields from port 0 all 4 cycles, busy_o=1 cycles 2-4, gnt_o=01 in cycle 4, port 1 granted next.
- Both ports request continuously, gnt every cycle -> grants alternate 01,10,01,10.
- hold_i=1 with port 1 req -> data_req=0, no gnt. hold_i raised while in LOCK -> locked request still completes on gnt.
- Port 1 forced to lose 8 times (starve counter driven to STARVE_LIMIT) -> next IDLE arbitration picks port 1 even when rr_ptr=0. Its counter clears on grant.
- rst_ni asserted in LOCK -> data_req, gnt_o and busy_o drop immediately (async). After release, the FSM is IDLE with rr_ptr=0.
